ctrl_wr_sched: RTL and testbench

Write-data scheduler for the DDR4 controller. It sits directly upstream of the write-data pin driver. It buffers write payloads accepted from the testbench/host side together with their burst length and preamble. On each WR command issued on the command bus, it times the CAS write latency and emits a one-cycle `wr_rdy` strobe with the matching descriptor. The pin driver uses that strobe to drive DQS/DQ.

---
 rtl/ddr_pkg.sv | 15 +
 rtl/wr_payload_fifo.sv | 52 +++++
 rtl/ctrl_wr_sched.sv | 108 ++++++++++
 tb/tb_ctrl_wr_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared DDR4 controller types: write descriptor layout and protocol constants.
package ddr_pkg;

    localparam int BL8       = 8;
    localparam int BL4       = 4;
    localparam int CWL_MIN   = 9;
    localparam int WR_DATA_W = 64;

    typedef struct packed {
        logic [3:0]           burst_length;
        logic [1:0]           preamable;
        logic [WR_DATA_W-1:0] wr_data;
    } wr_data_type;

endpackage

// File: rtl/wr_payload_fifo.sv
// Circular payload queue; the caller guarantees no push when full without a pop
// and no pop when empty.
module wr_payload_fifo
    import ddr_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wr_data_type
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else begin
            if (push) tail_q <= tail_q + AW'(1);
            if (pop)  head_q <= head_q + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; head/tail reset makes stale contents unreachable.
    always_ff @(posedge clk_sys) begin
        if (push) mem[tail_q] <= push_data;
    end

    assign head  = mem[head_q];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/ctrl_wr_sched.sv
// Write-data scheduler: binds queued payloads to WR commands and strobes each
// descriptor to the pin driver cwl - wr_pre cycles after its command.
module ctrl_wr_sched
    import ddr_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 64,
    parameter int CWL_MAX = 20
) (
    input  logic                   CK_t,
    input  logic                   reset,
    input  logic                   wr_req,
    input  logic [3:0]             wr_bl,
    input  logic [1:0]             wr_pre,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   req_rdy,
    input  logic                   wr_cmd,
    input  logic [4:0]             cwl,
    output logic                   wr_rdy,
    output logic [3:0]             out_bl,
    output logic [1:0]             out_pre,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   cmd_err,
    output logic                   ovf
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CWL_MAX-1:0] tokens_q;
    logic [CWL_MAX-1:0] tokens_ins;
    logic [CW-1:0]      unbound_q;
    logic [4:0]         delay;
    logic               launch;
    logic               push_ok;
    logic               sched;
    logic               full;
    logic               empty;
    logic               wr_rdy_q;
    logic               cmd_err_q;
    logic               ovf_q;
    wr_data_type        push_ent;
    wr_data_type        head_ent;
    wr_data_type        out_q;

    // A pop this cycle frees a slot, so a full queue can still accept a push.
    assign launch   = tokens_q[0];
    assign req_rdy  = !full || launch;
    assign push_ok  = wr_req && req_rdy;
    assign sched    = wr_cmd && (unbound_q != '0);
    assign delay    = cwl - {3'b000, wr_pre} - 5'd1;
    assign push_ent = '{burst_length: wr_bl, preamable: wr_pre, wr_data: wr_data};

    always_comb begin
        tokens_ins = '0;
        if (sched) tokens_ins[delay] = 1'b1;
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            tokens_q  <= '0;
            unbound_q <= '0;
            wr_rdy_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            out_q     <= '0;
        end else begin
            tokens_q  <= (tokens_q >> 1) | tokens_ins;
            wr_rdy_q  <= launch;
            cmd_err_q <= wr_cmd && (unbound_q == '0);
            if (launch)             out_q <= head_ent;
            if (wr_req && !req_rdy) ovf_q <= 1'b1;
            case ({push_ok, sched})
                2'b10:   unbound_q <= unbound_q + CW'(1);
                2'b01:   unbound_q <= unbound_q - CW'(1);
                default: ;
            endcase
        end
    end

    // Tokens exist only for bound entries, so a launch always finds a head.
    always @(posedge CK_t) begin
        if (!reset && launch) assert (!empty);
    end

    wr_payload_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wr_data_type)
    ) u_fifo (
        .clk_sys   (CK_t),
        .reset     (reset),
        .push      (push_ok),
        .push_data (push_ent),
        .pop       (launch),
        .head      (head_ent),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign wr_rdy   = wr_rdy_q;
    assign cmd_err  = cmd_err_q;
    assign ovf      = ovf_q;
    assign out_bl   = out_q.burst_length;
    assign out_pre  = out_q.preamable;
    assign out_data = out_q.wr_data;

endmodule

// File: tb/tb_ctrl_wr_sched.sv
// Bench for ctrl_wr_sched: queue/latency reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ctrl_wr_sched;

    localparam int DEPTH   = 4;
    localparam int DATA_W  = 64;
    localparam int CWL_MAX = 20;

    logic        CK_t = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [3:0]  wr_bl;
    logic [1:0]  wr_pre;
    logic [63:0] wr_data;
    logic        req_rdy;
    logic        wr_cmd;
    logic [4:0]  cwl;
    logic        wr_rdy;
    logic [3:0]  out_bl;
    logic [1:0]  out_pre;
    logic [63:0] out_data;
    logic [2:0]  count;
    logic        cmd_err;
    logic        ovf;

    ctrl_wr_sched #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CWL_MAX(CWL_MAX)) dut (
        .CK_t     (CK_t),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_bl    (wr_bl),
        .wr_pre   (wr_pre),
        .wr_data  (wr_data),
        .req_rdy  (req_rdy),
        .wr_cmd   (wr_cmd),
        .cwl      (cwl),
        .wr_rdy   (wr_rdy),
        .out_bl   (out_bl),
        .out_pre  (out_pre),
        .out_data (out_data),
        .count    (count),
        .cmd_err  (cmd_err),
        .ovf      (ovf)
    );

    always #5 CK_t = ~CK_t;

    typedef struct {
        logic [3:0]  bl;
        logic [1:0]  pre;
        logic [63:0] data;
    } ent_t;

    // Reference model: payload list, unclaimed count, absolute launch edges.
    ent_t        m_q[$];
    int          m_launch[$];
    int          m_unbound;
    int          ecnt;
    int          last_cwl;
    int          last_pre;
    logic        e_wr_rdy, e_cmd_err, e_ovf, e_req_rdy;
    logic [3:0]  e_bl;
    logic [1:0]  e_pre;
    logic [63:0] e_data;
    int          e_count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
        end
    endfunction

    task automatic model_edge();
        ent_t h;
        ent_t n;
        bit   launch;
        bit   pre_rdy;
        if (reset) begin
            m_q.delete();
            m_launch.delete();
            m_unbound = 0;
            ecnt      = 0;
            e_wr_rdy  = 1'b0;
            e_cmd_err = 1'b0;
            e_ovf     = 1'b0;
            e_bl      = '0;
            e_pre     = '0;
            e_data    = '0;
        end else begin
            if (m_q.size() != 0 && (int'(cwl) != last_cwl || int'(wr_pre) != last_pre)) begin
                n_err++;
                $display("FAIL cwl_change: cwl/pre changed with %0d entries queued", m_q.size());
            end
            ecnt++;
            pre_rdy  = e_req_rdy;
            launch   = (m_launch.size() > 0) && (m_launch[0] == ecnt);
            e_wr_rdy = launch;
            if (launch) begin
                void'(m_launch.pop_front());
                h      = m_q.pop_front();
                e_bl   = h.bl;
                e_pre  = h.pre;
                e_data = h.data;
            end
            e_cmd_err = wr_cmd && (m_unbound == 0);
            if (wr_cmd && m_unbound > 0) begin
                m_launch.push_back(ecnt + int'(cwl) - int'(wr_pre));
                m_unbound--;
            end
            if (wr_req) begin
                if (pre_rdy) begin
                    n.bl   = wr_bl;
                    n.pre  = wr_pre;
                    n.data = wr_data;
                    m_q.push_back(n);
                    m_unbound++;
                end else begin
                    e_ovf = 1'b1;
                end
            end
        end
        last_cwl  = int'(cwl);
        last_pre  = int'(wr_pre);
        e_count   = m_q.size();
        e_req_rdy = (m_q.size() < DEPTH) || (m_launch.size() > 0 && m_launch[0] == ecnt + 1);
    endtask

    always @(negedge CK_t) begin
        if (chk_en) begin
            check("wr_rdy",   64'(wr_rdy),   64'(e_wr_rdy));
            check("out_bl",   64'(out_bl),   64'(e_bl));
            check("out_pre",  64'(out_pre),  64'(e_pre));
            check("out_data", out_data,      e_data);
            check("count",    64'(count),    64'(e_count));
            check("req_rdy",  64'(req_rdy),  64'(e_req_rdy));
            check("cmd_err",  64'(cmd_err),  64'(e_cmd_err));
            check("ovf",      64'(ovf),      64'(e_ovf));
        end
    end

    // Called just after a falling edge; returns just after the next one.
    task automatic cycle(input bit rst, input bit req, input bit cmd,
                         input logic [63:0] d, input logic [3:0] bl);
        reset   = rst;
        wr_req  = req;
        wr_cmd  = cmd;
        wr_data = d;
        wr_bl   = bl;
        @(posedge CK_t);
        model_edge();
        chk_en = 1'b1;
        @(negedge CK_t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 64'h0, 4'd8);
    endtask

    task automatic watch(input int n, output int pulses, output int first_e,
                         output int last_e, output logic [63:0] last_d);
        pulses  = 0;
        first_e = -1;
        last_e  = -1;
        last_d  = '0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 64'h0, 4'd8);
            if (wr_rdy === 1'b1) begin
                if (pulses == 0) first_e = ecnt;
                last_e = ecnt;
                last_d = out_data;
                pulses++;
            end
        end
    endtask

    int          pulses, first_e, last_e;
    logic [63:0] last_d;

    initial begin
        reset   = 1'b1;
        wr_req  = 1'b0;
        wr_cmd  = 1'b0;
        wr_bl   = 4'd8;
        wr_pre  = 2'd1;
        wr_data = '0;
        cwl     = 5'd11;
        @(negedge CK_t);

        // single BL8 write, cwl=11 pre=1, command at edge 20
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 4'd8);
        check("t0_reset_req_rdy", 64'(req_rdy), 64'd1);
        check("t0_reset_count",   64'(count),   64'd0);
        cycle(1'b0, 1'b1, 1'b0, 64'h0807060504030201, 4'd8);
        check("t1_count_push", 64'(count), 64'd1);
        idle(18);
        cycle(1'b0, 1'b0, 1'b1, 64'h0, 4'd8);
        watch(15, pulses, first_e, last_e, last_d);
        check("t1_pulses",   64'(pulses),  64'd1);
        check("t1_rdy_edge", 64'(first_e), 64'd30);
        check("t1_out_data", out_data,     64'h0807060504030201);
        check("t1_out_bl",   64'(out_bl),  64'd8);
        check("t1_count",    64'(count),   64'd0);
        check("t1_model_count", 64'(e_count), 64'd0);

        // four pushes, four back-to-back commands, cwl=12 pre=2
        cwl    = 5'd12;
        wr_pre = 2'd2;
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 4'd8);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'h1111_0000_0000_0000 * i, 4'd8);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 64'h0, 4'd8);
        watch(20, pulses, first_e, last_e, last_d);
        check("t2_pulses",     64'(pulses),  64'd4);
        check("t2_first_edge", 64'(first_e), 64'd15);
        check("t2_last_edge",  64'(last_e),  64'd18);
        check("t2_last_data",  last_d,       64'h4444_0000_0000_0000);
        check("t2_out_pre",    64'(out_pre), 64'd2);

        // overflow: five pushes into a four-deep queue
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 4'd8);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'hA0 + 64'(i), 4'd4);
        check("t3_req_rdy_full", 64'(req_rdy), 64'd0);
        check("t3_count_full",   64'(count),   64'd4);
        check("t3_ovf_before",   64'(ovf),     64'd0);
        cycle(1'b0, 1'b1, 1'b0, 64'hA5, 4'd4);
        check("t3_ovf",   64'(ovf),   64'd1);
        check("t3_count", 64'(count), 64'd4);

        // command with nothing queued
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 4'd8);
        cycle(1'b0, 1'b0, 1'b1, 64'h0, 4'd8);
        check("t4_cmd_err", 64'(cmd_err), 64'd1);
        idle(1);
        check("t4_cmd_err_clr", 64'(cmd_err), 64'd0);
        watch(CWL_MAX, pulses, first_e, last_e, last_d);
        check("t4_no_rdy", 64'(pulses), 64'd0);

        // full queue: push lands in the same cycle as a launch pop
        cwl    = 5'd11;
        wr_pre = 2'd1;
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 4'd8);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'hC0 + 64'(i), 4'd8);
        cycle(1'b0, 1'b0, 1'b1, 64'h0, 4'd8);
        idle(9);
        check("t5_req_rdy_pop", 64'(req_rdy), 64'd1);
        check("t5_count_pre",   64'(count),   64'd4);
        cycle(1'b0, 1'b1, 1'b0, 64'hEE, 4'd4);
        check("t5_wr_rdy",  64'(wr_rdy), 64'd1);
        check("t5_first",   out_data,    64'hC1);
        check("t5_count",   64'(count),  64'd4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 64'h0, 4'd8);
        watch(20, pulses, first_e, last_e, last_d);
        check("t5_pulses", 64'(pulses), 64'd4);
        check("t5_last",   last_d,      64'hEE);
        check("t5_last_bl", 64'(out_bl), 64'd4);

        // reset three cycles after a command discards the pending launch
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 4'd8);
        cycle(1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF, 4'd8);
        cycle(1'b0, 1'b0, 1'b1, 64'h0, 4'd8);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 4'd8);
        check("t6_count",   64'(count),   64'd0);
        check("t6_req_rdy", 64'(req_rdy), 64'd1);
        check("t6_data",    out_data,     64'h0);
        watch(CWL_MAX + 5, pulses, first_e, last_e, last_d);
        check("t6_no_rdy", 64'(pulses), 64'd0);

        // randomized traffic; latency only changes with nothing in flight
        for (int i = 0; i < 4000; i++) begin
            if (m_q.size() == 0 && m_launch.size() == 0 && $urandom_range(0, 49) == 0) begin
                cwl    = 5'($urandom_range(9, CWL_MAX));
                wr_pre = 2'($urandom_range(1, 2));
            end
            cycle($urandom_range(0, 499) == 0,
                  $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 30,
                  {$urandom, $urandom},
                  ($urandom_range(0, 1) == 1) ? 4'd8 : 4'd4);
        end
        idle(CWL_MAX + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
